fifo_wr_arbiter: RTL and testbench
==================================

// Module: fifo_wr_arbiter
// PURPOSE
//  Round-robin burst arbiter sharing one fifo write port among NUM_REQ producers
//  (e.g. CNN feature-map writers feeding the BiLSTM input buffer).
//  Grants one requester at a time and forwards its words to the fifo.
//  A burst ends on BURST_LEN words, on req_last, or when the requester drops req.
//  Throttles on fifo_full and never writes into a full fifo.
// PARAMETERS
//  NUM_REQ    4                      number of producers (>=2)
//  DATA_WIDTH 16                     word width, matches fifo DATA_WIDTH
//  BURST_LEN  8                      max words per grant (>=1)
//  CNT_W      $clog2(BURST_LEN+1)    beat counter width
// PORTS
//  clk          in   1                   clock, rising edge
//  rst          in   1                   synchronous reset, active-high
//  req          in   NUM_REQ             producer i has a word on req_data[i]
//  req_data     in   NUM_REQ*DATA_WIDTH  word of producer i at bits [i*DATA_WIDTH +: DATA_WIDTH]
//  req_last     in   NUM_REQ             current word of producer i ends its packet
//  req_ack      out  NUM_REQ             one-hot; word of producer i accepted this cycle
//  grant        out  NUM_REQ             one-hot registered grant; all zero when idle
//  fifo_wr_data out  DATA_WIDTH          to fifo wr_data
//  fifo_wr_en   out  1                   to fifo wr_en
//  fifo_full    in   1                   from fifo full
//  busy         out  1                   high in GRANT state
// BEHAVIOUR
//  - One clock, synchronous active-high reset. On rst: state=IDLE, grant=0,
//    beat_cnt=0, last_gnt=NUM_REQ-1 (requester 0 has top priority first).
//    req_ack, fifo_wr_en, busy and fifo_wr_data are 0 during and after reset.
//  - FSM IDLE -> GRANT -> IDLE.
//    IDLE: if |req, select the first requester with req high, searching
//      last_gnt+1, last_gnt+2, ... modulo NUM_REQ. Register it as one-hot grant
//      and go to GRANT. beat_cnt<=0. Arbitration latency is 1 cycle (req -> grant).
//    GRANT (g = granted index):
//      fifo_wr_en = req[g] & ~fifo_full (combinational).
//      req_ack[g] = fifo_wr_en. Other req_ack bits = 0.
//      fifo_wr_data = req_data[g] slice. Zero when fifo_wr_en is 0.
//      On an accepted word, beat_cnt += 1.
//      Release (next state IDLE, grant<=0, last_gnt<=g) when either:
//        (a) an accepted word has req_last[g]=1 or beat_cnt+1==BURST_LEN, or
//        (b) req[g]=0 in a GRANT cycle.
//      (a) and (b) cannot coincide. Simultaneous last and BURST_LEN cause one release.
//  - One dead cycle (IDLE) between bursts. A requester is never re-granted
//    back-to-back if another requester has req high.
//  - fifo_full with req[g]=1: hold grant, no write, no ack, beat_cnt frozen.
//    There is no timeout.
//  - Requests of non-granted producers are ignored. Producers hold data until acked.
//  - Reset mid-burst aborts the burst. No further fifo_wr_en until a new grant.
// TESTING
//  1 req=4'b0010, 3 words, last on 3rd, fifo empty -> grant=0010 1 cycle later;
//    3 consecutive wr_en/ack[1]; grant=0 after 3rd; busy low.
//  2 req=4'b1111 held, no last, BURST_LEN=8 -> grants 0,1,2,3,0 in order;
//    exactly 8 writes each; 1 idle cycle between bursts.
//  3 fifo_full high 5 cycles after beat 3 of a burst -> wr_en=0 and ack=0 for those
//    5 cycles; grant held; burst still totals 8 words; data order intact.
//  4 requester 2 drops req after 2 accepted beats while req[3]=1 -> release;
//    next grant=1000; fifo receives exactly 2 words from requester 2.
//  5 rst pulsed mid-burst of requester 1, then req=4'b0101 -> all outputs 0 during
//    rst; first grant after reset=0001.
//  6 req_last asserted on beat 8 of a burst -> single release; beat count 8;
//    no 9th write.

Source files
------------

// File: rtl/fifo_wr_arbiter_if.sv
// Handshake bundle between NUM_REQ producers, the write arbiter and one fifo
// write port. The arbiter connects through the master modport; the producer
// and fifo side connects through the slave modport.
interface fifo_wr_arbiter_if #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 16
);
  logic [NUM_REQ-1:0]            req;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]            req_last;
  logic [NUM_REQ-1:0]            req_ack;
  logic [NUM_REQ-1:0]            grant;
  logic [DATA_WIDTH-1:0]         fifo_wr_data;
  logic                          fifo_wr_en;
  logic                          fifo_full;
  logic                          busy;

  modport master (
    input  req, req_data, req_last, fifo_full,
    output req_ack, grant, fifo_wr_data, fifo_wr_en, busy
  );

  modport slave (
    output req, req_data, req_last, fifo_full,
    input  req_ack, grant, fifo_wr_data, fifo_wr_en, busy
  );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter sharing one fifo write port among NUM_REQ
// producers. One requester owns the port per burst; a burst ends on
// BURST_LEN accepted words, on req_last, or when the owner drops req.
// Writes are throttled by fifo_full and never target a full fifo.

// Structural checks on the arbiter outputs, kept apart from the datapath.
module fifo_wr_arbiter_chk #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 16
) (
  input logic                  clk,
  input logic                  rst,
  input logic [NUM_REQ-1:0]    grant,
  input logic [NUM_REQ-1:0]    req_ack,
  input logic [DATA_WIDTH-1:0] fifo_wr_data,
  input logic                  fifo_wr_en,
  input logic                  fifo_full,
  input logic                  busy
);
  a_grant_onehot0: assert property (@(posedge clk) disable iff (rst) $onehot0(grant));
  a_ack_onehot0:   assert property (@(posedge clk) disable iff (rst) $onehot0(req_ack));
  a_no_full_write: assert property (@(posedge clk) disable iff (rst) !(fifo_wr_en && fifo_full));
  a_ack_is_write:  assert property (@(posedge clk) disable iff (rst) ((req_ack != '0) == fifo_wr_en));
  a_ack_in_grant:  assert property (@(posedge clk) disable iff (rst) ((req_ack & ~grant) == '0));
  a_busy_grant:    assert property (@(posedge clk) disable iff (rst) (busy == (grant != '0)));
  a_data_zero:     assert property (@(posedge clk) disable iff (rst) (fifo_wr_en || (fifo_wr_data == '0)));
endmodule

module fifo_wr_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 16,
  parameter int BURST_LEN  = 8,
  parameter int CNT_W      = $clog2(BURST_LEN + 1)
) (
  input logic               clk,
  input logic               rst,
  fifo_wr_arbiter_if.master bus
);

  localparam int IDX_W = $clog2(NUM_REQ);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_e;

  state_e                 state_r;
  state_e                 state_nxt_s;
  logic [NUM_REQ-1:0]     grant_r;
  logic [NUM_REQ-1:0]     grant_nxt_s;
  logic [IDX_W-1:0]       gnt_idx_r;
  logic [IDX_W-1:0]       gnt_idx_nxt_s;
  logic [IDX_W-1:0]       last_gnt_r;
  logic [IDX_W-1:0]       last_gnt_nxt_s;
  logic [CNT_W-1:0]       beat_cnt_r;
  logic [CNT_W-1:0]       beat_cnt_nxt_s;

  logic                   pick_vld_s;
  logic [IDX_W-1:0]       pick_idx_s;
  logic                   req_g_s;
  logic                   last_g_s;
  logic [DATA_WIDTH-1:0]  data_g_s;
  logic                   wr_en_s;
  logic                   burst_end_s;
  logic                   release_s;

  // Round-robin search starting just after the previous owner. Returns
  // {found, index}; the first hit in search order wins.
  function automatic logic [IDX_W:0] rr_pick(
    input logic [NUM_REQ-1:0] r,
    input logic [IDX_W-1:0]   last
  );
    logic             found;
    logic [IDX_W-1:0] idx;
    logic [IDX_W-1:0] cand_idx;
    logic             hit;
    int unsigned      cand;
    found = 1'b0;
    idx   = {IDX_W{1'b0}};
    for (int unsigned k = 32'd1; k <= 32'(NUM_REQ); k++) begin
      cand     = (32'(last) + k) % 32'(NUM_REQ);
      cand_idx = IDX_W'(cand);
      hit      = r[cand_idx] & ~found;
      idx      = hit ? cand_idx : idx;
      found    = found | r[cand_idx];
    end
    return {found, idx};
  endfunction

  // Next owner candidate while idle.
  always_comb begin
    {pick_vld_s, pick_idx_s} = rr_pick(bus.req, last_gnt_r);
  end

  // Signals of the currently granted producer and the write qualification.
  always_comb begin
    req_g_s     = bus.req[gnt_idx_r];
    last_g_s    = bus.req_last[gnt_idx_r];
    data_g_s    = bus.req_data[gnt_idx_r * DATA_WIDTH +: DATA_WIDTH];
    wr_en_s     = (state_r == ST_GRANT) & req_g_s & ~bus.fifo_full;
    burst_end_s = wr_en_s & (last_g_s | ((beat_cnt_r + CNT_W'(1)) == CNT_W'(BURST_LEN)));
    release_s   = (state_r == ST_GRANT) & (burst_end_s | ~req_g_s);
  end

  // Next-state and next-register values for the IDLE/GRANT controller.
  always_comb begin
    state_nxt_s    = state_r;
    grant_nxt_s    = grant_r;
    gnt_idx_nxt_s  = gnt_idx_r;
    last_gnt_nxt_s = last_gnt_r;
    beat_cnt_nxt_s = beat_cnt_r;
    case (state_r)
      ST_IDLE: begin
        beat_cnt_nxt_s = {CNT_W{1'b0}};
        if (pick_vld_s) begin
          state_nxt_s   = ST_GRANT;
          grant_nxt_s   = NUM_REQ'(1) << pick_idx_s;
          gnt_idx_nxt_s = pick_idx_s;
        end else begin
          state_nxt_s   = ST_IDLE;
        end
      end
      ST_GRANT: begin
        if (release_s) begin
          state_nxt_s    = ST_IDLE;
          grant_nxt_s    = {NUM_REQ{1'b0}};
          last_gnt_nxt_s = gnt_idx_r;
          beat_cnt_nxt_s = {CNT_W{1'b0}};
        end else if (wr_en_s) begin
          beat_cnt_nxt_s = beat_cnt_r + CNT_W'(1);
        end else begin
          beat_cnt_nxt_s = beat_cnt_r;
        end
      end
      default: begin
        state_nxt_s    = ST_IDLE;
        grant_nxt_s    = {NUM_REQ{1'b0}};
        beat_cnt_nxt_s = {CNT_W{1'b0}};
      end
    endcase
  end

  // State and arbitration registers; last_gnt starts at the top index so
  // requester 0 is searched first after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= ST_IDLE;
      grant_r    <= {NUM_REQ{1'b0}};
      gnt_idx_r  <= {IDX_W{1'b0}};
      last_gnt_r <= IDX_W'(NUM_REQ - 1);
      beat_cnt_r <= {CNT_W{1'b0}};
    end else begin
      state_r    <= state_nxt_s;
      grant_r    <= grant_nxt_s;
      gnt_idx_r  <= gnt_idx_nxt_s;
      last_gnt_r <= last_gnt_nxt_s;
      beat_cnt_r <= beat_cnt_nxt_s;
    end
  end

  // Port outputs; forced to zero while reset is applied so a burst cut by
  // reset cannot leak a write in the reset cycle.
  always_comb begin
    bus.grant        = {NUM_REQ{1'b0}};
    bus.busy         = 1'b0;
    bus.fifo_wr_en   = 1'b0;
    bus.fifo_wr_data = {DATA_WIDTH{1'b0}};
    bus.req_ack      = {NUM_REQ{1'b0}};
    if (rst) begin
      bus.grant      = {NUM_REQ{1'b0}};
      bus.fifo_wr_en = 1'b0;
    end else begin
      bus.grant        = grant_r;
      bus.busy         = (state_r == ST_GRANT);
      bus.fifo_wr_en   = wr_en_s;
      bus.fifo_wr_data = wr_en_s ? data_g_s : {DATA_WIDTH{1'b0}};
      bus.req_ack      = wr_en_s ? grant_r : {NUM_REQ{1'b0}};
    end
  end

  fifo_wr_arbiter_chk #(
    .NUM_REQ    (NUM_REQ),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_chk (
    .clk          (clk),
    .rst          (rst),
    .grant        (bus.grant),
    .req_ack      (bus.req_ack),
    .fifo_wr_data (bus.fifo_wr_data),
    .fifo_wr_en   (bus.fifo_wr_en),
    .fifo_full    (bus.fifo_full),
    .busy         (bus.busy)
  );

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Self-checking bench for fifo_wr_arbiter: directed scenarios with literal
// expectations plus a randomized phase, all checked every cycle against a
// behavioural owner/count model of the arbitration rules.
module tb_fifo_wr_arbiter;
  localparam int NUM_REQ    = 4;
  localparam int DATA_WIDTH = 16;
  localparam int BURST_LEN  = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;

  fifo_wr_arbiter_if #(.NUM_REQ(NUM_REQ), .DATA_WIDTH(DATA_WIDTH)) bus ();

  fifo_wr_arbiter #(
    .NUM_REQ    (NUM_REQ),
    .DATA_WIDTH (DATA_WIDTH),
    .BURST_LEN  (BURST_LEN)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Producer state: want = producer wishes to send, words_left = words still
  // to send (-1 means endless, last never set), cur_word = held word.
  logic [NUM_REQ-1:0]    want;
  int                    words_left [NUM_REQ];
  logic [DATA_WIDTH-1:0] cur_word   [NUM_REQ];

  // Reference model: current owner (-1 when nobody owns the port), accepted
  // words in the current burst, and the last owner for round-robin order.
  int                 m_owner = -1;
  int                 m_cnt   = 0;
  int                 m_last  = NUM_REQ - 1;
  logic [NUM_REQ-1:0] exp_ack = '0;

  // Observations of the DUT used by the directed scenarios.
  int                 dut_wr_cnt [NUM_REQ];
  int                 gnt_log [$];
  logic [NUM_REQ-1:0] prev_grant = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic apply();
    for (int i = 0; i < NUM_REQ; i++) begin
      bus.req[i]      = want[i] && (words_left[i] != 0);
      bus.req_last[i] = (words_left[i] == 1);
      bus.req_data[i*DATA_WIDTH +: DATA_WIDTH] = cur_word[i];
    end
  endtask

  // Advance one clock; producers whose word was accepted present a new one.
  task automatic cycle();
    @(posedge clk);
    #1;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (exp_ack[i]) begin
        cur_word[i] = DATA_WIDTH'($urandom);
        if (words_left[i] > 0) words_left[i]--;
      end
    end
    apply();
  endtask

  task automatic clear_logs();
    for (int i = 0; i < NUM_REQ; i++) dut_wr_cnt[i] = 0;
    gnt_log.delete();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    want = '0;
    bus.fifo_full = 1'b0;
    apply();
    cycle();
    cycle();
    rst = 1'b0;
    clear_logs();
    apply();
  endtask

  // Model evaluation and per-cycle comparison, sampled on the falling edge.
  always @(negedge clk) begin : model
    logic [NUM_REQ-1:0]    e_grant;
    logic [NUM_REQ-1:0]    e_ack;
    logic                  e_wr;
    logic                  e_busy;
    logic [DATA_WIDTH-1:0] e_data;
    int                    pick;
    int                    g;
    logic [1:0]            ix;
    e_grant = '0; e_ack = '0; e_wr = 1'b0; e_busy = 1'b0; e_data = '0;
    if (rst) begin
      m_owner = -1; m_cnt = 0; m_last = NUM_REQ - 1;
    end else if (m_owner < 0) begin
      pick = -1;
      for (int k = 1; k <= NUM_REQ; k++) begin
        ix = 2'((m_last + k) % NUM_REQ);
        if (pick < 0 && bus.req[ix]) pick = int'(ix);
      end
      if (pick >= 0) begin
        m_owner = pick;
        m_cnt   = 0;
      end
    end else begin
      g  = m_owner;
      ix = 2'(g);
      e_grant[ix] = 1'b1;
      e_busy = 1'b1;
      e_wr = bus.req[ix] && !bus.fifo_full;
      if (e_wr) begin
        e_ack[ix] = 1'b1;
        e_data = bus.req_data[g*DATA_WIDTH +: DATA_WIDTH];
        m_cnt++;
      end
      if ((e_wr && (bus.req_last[ix] || m_cnt == BURST_LEN)) || !bus.req[ix]) begin
        m_last  = g;
        m_owner = -1;
      end
    end
    chk("grant", 32'(bus.grant), 32'(e_grant));
    chk("req_ack", 32'(bus.req_ack), 32'(e_ack));
    chk("fifo_wr_en", 32'(bus.fifo_wr_en), 32'(e_wr));
    chk("fifo_wr_data", 32'(bus.fifo_wr_data), 32'(e_data));
    chk("busy", 32'(bus.busy), 32'(e_busy));
    exp_ack = e_ack;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (bus.fifo_wr_en && bus.req_ack[i]) dut_wr_cnt[i]++;
      if (prev_grant == '0 && bus.grant[i]) gnt_log.push_back(i);
    end
    prev_grant = bus.grant;
  end

  initial begin
    int n;
    want = '0;
    bus.fifo_full = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      words_left[i] = 0;
      cur_word[i]   = DATA_WIDTH'($urandom);
    end
    clear_logs();
    apply();

    // Reset state.
    do_reset();
    #1;
    chk("reset_grant", 32'(bus.grant), 32'h0);
    chk("reset_busy", 32'(bus.busy), 32'h0);

    // 1: single requester, 3-word packet.
    words_left[1] = 3;
    want = 4'b0010;
    apply();
    cycle();
    chk("t1_grant_latency", 32'(bus.grant), 32'h2);
    n = 0;
    while (n < 20 && bus.busy) begin
      cycle();
      n++;
    end
    chk("t1_burst_cycles", 32'(n), 32'd3);
    chk("t1_writes", 32'(dut_wr_cnt[1]), 32'd3);
    chk("t1_grant_after", 32'(bus.grant), 32'h0);

    // 2: all requesting, endless packets -> 0,1,2,3,0 with 8 words each.
    do_reset();
    for (int i = 0; i < NUM_REQ; i++) words_left[i] = -1;
    want = 4'b1111;
    apply();
    for (int k = 0; k < 200 && gnt_log.size() < 5; k++) cycle();
    chk("t2_grants", 32'(gnt_log.size()), 32'd5);
    for (int i = 0; i < 5 && i < gnt_log.size(); i++) chk("t2_order", 32'(gnt_log[i]), 32'(i % NUM_REQ));
    for (int i = 1; i < NUM_REQ; i++) chk("t2_burst_words", 32'(dut_wr_cnt[i]), 32'd8);

    // 3: fifo_full for 5 cycles after beat 3.
    do_reset();
    words_left[0] = -1;
    want = 4'b0001;
    apply();
    for (int k = 0; k < 50 && dut_wr_cnt[0] < 3; k++) cycle();
    bus.fifo_full = 1'b1;
    apply();
    for (int j = 0; j < 5; j++) begin
      #1;
      chk("t3_wr_en_full", 32'(bus.fifo_wr_en), 32'h0);
      chk("t3_ack_full", 32'(bus.req_ack), 32'h0);
      chk("t3_grant_hold", 32'(bus.grant), 32'h1);
      cycle();
    end
    bus.fifo_full = 1'b0;
    apply();
    for (int k = 0; k < 50 && bus.busy; k++) cycle();
    chk("t3_burst_words", 32'(dut_wr_cnt[0]), 32'd8);
    want = '0;
    apply();

    // 4: requester 2 drops req after 2 beats while 3 waits.
    do_reset();
    words_left[2] = -1;
    words_left[3] = -1;
    want = 4'b1100;
    apply();
    for (int k = 0; k < 50 && dut_wr_cnt[2] < 2; k++) cycle();
    want[2] = 1'b0;
    apply();
    for (int k = 0; k < 50 && gnt_log.size() < 2; k++) cycle();
    chk("t4_grants", 32'(gnt_log.size()), 32'd2);
    if (gnt_log.size() >= 2) begin
      chk("t4_first", 32'(gnt_log[0]), 32'd2);
      chk("t4_next", 32'(gnt_log[1]), 32'd3);
    end
    chk("t4_words_req2", 32'(dut_wr_cnt[2]), 32'd2);

    // 5: reset mid-burst of requester 1, then 0101 requesting.
    do_reset();
    words_left[1] = -1;
    want = 4'b0010;
    apply();
    for (int k = 0; k < 50 && dut_wr_cnt[1] < 2; k++) cycle();
    rst = 1'b1;
    apply();
    #1;
    chk("t5_rst_grant", 32'(bus.grant), 32'h0);
    chk("t5_rst_wr_en", 32'(bus.fifo_wr_en), 32'h0);
    chk("t5_rst_busy", 32'(bus.busy), 32'h0);
    chk("t5_rst_ack", 32'(bus.req_ack), 32'h0);
    cycle();
    cycle();
    words_left[0] = -1;
    words_left[2] = -1;
    want = 4'b0101;
    rst = 1'b0;
    clear_logs();
    apply();
    for (int k = 0; k < 20 && gnt_log.size() < 1; k++) cycle();
    chk("t5_grants", 32'(gnt_log.size()), 32'd1);
    if (gnt_log.size() >= 1) chk("t5_first_grant", 32'(gnt_log[0]), 32'd0);
    chk("t5_no_req1_write", 32'(dut_wr_cnt[1]), 32'd0);

    // 6: last on beat 8 coincides with the burst limit.
    do_reset();
    words_left[0] = 8;
    want = 4'b0001;
    apply();
    cycle();
    for (int k = 0; k < 50 && bus.busy; k++) cycle();
    for (int k = 0; k < 5; k++) cycle();
    chk("t6_words", 32'(dut_wr_cnt[0]), 32'd8);
    chk("t6_single_grant", 32'(gnt_log.size()), 32'd1);

    // Randomized phase, checked by the model every cycle.
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      cycle();
      for (int i = 0; i < NUM_REQ; i++) begin
        if (words_left[i] == 0 && $urandom_range(0, 3) == 0)
          words_left[i] = ($urandom_range(0, 4) == 0) ? -1 : int'($urandom_range(1, 12));
        if ($urandom_range(0, 15) == 0) want[i] = ~want[i];
      end
      bus.fifo_full = ($urandom_range(0, 4) == 0);
      apply();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
